inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage of the Risc-Inci core. It generates sequential PCs, issues word reads to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. It drives the instruction word, its PC and a data-valid flag into `instDecoder`. It also honours decoder stalls and pipeline flush/redirect requests from the execute stage.

## Interface
- `cXLEN`, 32: address/data width.
- `cResetPc`, 0: first fetch address after reset; must be 4-byte aligned.
- `cFifoDepth`, 4: instruction buffer depth; power of two, 2..16. Also caps outstanding requests.
- `cNop`, 32'h00000013: word driven on `oInst` when no valid instruction is present (`addi x0,x0,0`).

Ports:
- `iClk` in 1: clock, rising edge.
- `iRst` in 1: asynchronous, active-high reset.
- `oMemReqValid` out 1: read request valid.
- `oMemReqAddr` out cXLEN: read address, word aligned.
- `iMemReqReady` in 1: memory accepts the request this cycle.
- `iMemRspValid` in 1: read data valid. Responses return in request order, latency ≥1 cycle.
- `iMemRspData` in 32: read data.
- `iStall` in 1: decoder cannot take a new instruction; hold outputs.
- `iFlushPipe` in 1: discard all fetched/in-flight instructions and redirect.
- `iRedirectPc` in cXLEN: new fetch PC, sampled when `iFlushPipe`=1. Bits [1:0] are forced to 0.
- `oInst` out 32: instruction to decoder (`iInst`).
- `oCurPc` out cXLEN: PC of `oInst` (`iCurPC`).
- `oInstDv` out 1: `oInst`/`oCurPc` hold a real instruction.

## Operation
- State: `fetchPc`; outstanding counter `outCnt` (0..cFifoDepth); drop counter `dropCnt` (≤ `outCnt`); PC queue for outstanding requests (depth cFifoDepth); instruction FIFO of {inst, pc} (depth cFifoDepth); output register.
- Issue rule: `oMemReqValid` = !`iFlushPipe` && (`outCnt` + fifoCount < cFifoDepth). `oMemReqAddr` = `fetchPc`.
- Request accept = `oMemReqValid` && `iMemReqReady`. On accept: push `fetchPc` to PC queue, `outCnt`++, `fetchPc` += 4 (wraps mod 2^cXLEN).
- While valid && !ready, the address is stable. Valid drops only when credits are exhausted or a flush occurs.
- Response: pop PC queue, `outCnt`--. If `dropCnt`>0, the word is discarded and `dropCnt`--. Otherwise the word goes to the output register or FIFO, per the next rule.
- Output register load (when !`iStall`): source is the FIFO head if non-empty. If the FIFO is empty, an arriving live response bypasses directly into the register. Otherwise the register loads `cNop`, `oInstDv`=0, and `oCurPc` holds its old value. A live response not bypassed is pushed to the FIFO.
- `iStall`=1: the output register holds; live responses are pushed to the FIFO. The credit rule guarantees the FIFO never overflows.
- Flush (priority over stall and response), same edge:
  - FIFO cleared.
  - Output register ← `cNop`, `oInstDv` ← 0.
  - `fetchPc` ← {`iRedirectPc`[cXLEN-1:2], 2'b00}.
  - `dropCnt` ← `outCnt` minus 1 if a response arrives this cycle (that response is dropped).
  - No request is issued in the flush cycle.
- Simultaneous accept and response: `outCnt` unchanged, PC queue push and pop both happen.

## Timing
- Reset values: `oMemReqValid`=0, `oMemReqAddr`=cResetPc, `oInst`=cNop, `oCurPc`=0, `oInstDv`=0, counters 0, FIFO empty, `fetchPc`=cResetPc.
- First request is asserted in the first cycle after `iRst` deasserts.
- Latency: a response in cycle N with an empty FIFO and no stall gives `oInstDv`=1 in cycle N+1.
- With a 1-cycle memory and `iMemReqReady`=1, throughput is one instruction per cycle.
- Flush in cycle N gives `oInstDv`=0 in N+1 and a request at `iRedirectPc` in N+1. First redirected instruction reaches `oInst` ≥ N+3 for a 1-cycle memory, after stale responses are drained.
- `iFlushPipe` asserted together with `iRst` has no effect; reset dominates.

## Test plan
- Reset release, 1-cycle memory returning `addr`, ready=1 -> `oInstDv`=1 from cycle 3; `oCurPc` = 0,4,8,… with `oInst`==`oCurPc`, no gaps.
- `iStall` high 6 cycles mid-stream -> outputs frozen. `oMemReqValid` drops once 4 words are buffered/in flight. After release, sequence continues with no loss or duplication.
- Memory with 3-cycle latency and 2 outstanding, flush to 0x100 -> both stale responses dropped; next valid `oCurPc`=0x100, then 0x104.
- Flush with `iRedirectPc`=0x203 while a response arrives the same cycle -> that response dropped; next valid `oCurPc`=0x200.
- `cResetPc`=0xFFFFFFF8 -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
- `iMemReqReady` toggling randomly and `iRst` asserted mid-burst -> `oMemReqAddr` stable while stalled. Reset returns all outputs to reset values asynchronously; fetch restarts at cResetPc.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: sequential PC generation, credit-limited word reads,
// in-order response buffering and an output register feeding the decoder.
module inst_fetch #(
    parameter int unsigned      cXLEN      = 32,
    parameter logic [cXLEN-1:0] cResetPc   = '0,
    parameter int unsigned      cFifoDepth = 4,
    parameter logic [31:0]      cNop       = 32'h0000_0013
) (
    input  logic             iClk,
    input  logic             iRst,
    output logic             oMemReqValid,
    output logic [cXLEN-1:0] oMemReqAddr,
    input  logic             iMemReqReady,
    input  logic             iMemRspValid,
    input  logic [31:0]      iMemRspData,
    input  logic             iStall,
    input  logic             iFlushPipe,
    input  logic [cXLEN-1:0] iRedirectPc,
    output logic [31:0]      oInst,
    output logic [cXLEN-1:0] oCurPc,
    output logic             oInstDv
);
    localparam int unsigned AW    = (cFifoDepth > 1) ? $clog2(cFifoDepth) : 1;
    localparam int unsigned CW    = AW + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(cFifoDepth);

    logic [cXLEN-1:0] fetch_pc;
    logic [CW-1:0]    out_cnt, drop_cnt, fifo_cnt;
    logic [AW-1:0]    pcq_wr, pcq_rd, fifo_wr, fifo_rd;
    logic [cXLEN-1:0] pcq [cFifoDepth];
    logic [31:0]      fifo_inst [cFifoDepth];
    logic [cXLEN-1:0] fifo_pc [cFifoDepth];
    logic [31:0]      inst_q;
    logic [cXLEN-1:0] pc_q;
    logic             dv_q;

    logic             credit_ok, req_valid, accept, rsp, drop, live;
    logic             fifo_empty, load, pop, bypass, push;
    logic [cXLEN-1:0] rsp_pc;

    always_comb begin
        credit_ok  = ({1'b0, out_cnt} + {1'b0, fifo_cnt}) < DEPTH;
        req_valid  = !iRst && !iFlushPipe && credit_ok;
        accept     = req_valid && iMemReqReady;
        rsp        = iMemRspValid && (out_cnt != '0);
        drop       = rsp && (drop_cnt != '0);
        live       = rsp && !drop && !iFlushPipe;
        rsp_pc     = pcq[pcq_rd];
        fifo_empty = (fifo_cnt == '0);
        load       = !iFlushPipe && !iStall;
        pop        = load && !fifo_empty;
        bypass     = load && fifo_empty && live;
        push       = live && !bypass;
    end

    // Storage arrays carry no reset; pointers and counters define their contents.
    always_ff @(posedge iClk) begin
        if (accept) begin
            pcq[pcq_wr] <= fetch_pc;
        end
        if (push) begin
            fifo_inst[fifo_wr] <= iMemRspData;
            fifo_pc[fifo_wr]   <= rsp_pc;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            fetch_pc <= cResetPc;
            out_cnt  <= '0;
            drop_cnt <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
            inst_q   <= cNop;
            pc_q     <= '0;
            dv_q     <= 1'b0;
        end else begin
            if (iFlushPipe) begin
                fetch_pc <= iRedirectPc & ~cXLEN'(3);
            end else if (accept) begin
                fetch_pc <= fetch_pc + cXLEN'(4);
            end

            if (accept) begin
                pcq_wr <= pcq_wr + 1'b1;
            end
            if (rsp) begin
                pcq_rd <= pcq_rd + 1'b1;
            end
            out_cnt <= out_cnt + CW'(accept) - CW'(rsp);

            // Everything still in flight after this edge belongs to the old stream.
            if (iFlushPipe) begin
                drop_cnt <= out_cnt - CW'(rsp);
            end else if (drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end

            if (iFlushPipe) begin
                fifo_wr  <= '0;
                fifo_rd  <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push) begin
                    fifo_wr <= fifo_wr + 1'b1;
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + 1'b1;
                end
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end

            if (iFlushPipe) begin
                inst_q <= cNop;
                dv_q   <= 1'b0;
            end else if (!iStall) begin
                if (!fifo_empty) begin
                    inst_q <= fifo_inst[fifo_rd];
                    pc_q   <= fifo_pc[fifo_rd];
                    dv_q   <= 1'b1;
                end else if (live) begin
                    inst_q <= iMemRspData;
                    pc_q   <= rsp_pc;
                    dv_q   <= 1'b1;
                end else begin
                    inst_q <= cNop;
                    dv_q   <= 1'b0;
                end
            end
        end
    end

    assign oMemReqValid = req_valid;
    assign oMemReqAddr  = fetch_pc;
    assign oInst        = inst_q;
    assign oCurPc       = pc_q;
    assign oInstDv      = dv_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: randomized memory/stall/flush traffic checked against an
// in-order PC stream model, plus directed latency, stall, flush, wrap and reset steps.
module tb_inst_fetch;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk, rst;
    logic        req_valid, ready, rsp_valid, stall, flush, inst_dv;
    logic [31:0] req_addr, rsp_data, redirect, inst, cur_pc;

    logic        w_valid, w_rsp_valid, w_dv;
    logic [31:0] w_addr, w_rsp_data, w_inst, w_pc;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    req_t        pend[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc, lat, consumed, mark;
    logic [31:0] exp_pc, exp_req;
    logic        prev_valid, prev_ready, prev_live;

    inst_fetch #(.cXLEN(32), .cResetPc(32'h0), .cFifoDepth(4), .cNop(NOP)) dut (
        .iClk(clk), .iRst(rst),
        .oMemReqValid(req_valid), .oMemReqAddr(req_addr), .iMemReqReady(ready),
        .iMemRspValid(rsp_valid), .iMemRspData(rsp_data),
        .iStall(stall), .iFlushPipe(flush), .iRedirectPc(redirect),
        .oInst(inst), .oCurPc(cur_pc), .oInstDv(inst_dv)
    );

    inst_fetch #(.cXLEN(32), .cResetPc(WRAP_PC), .cFifoDepth(4), .cNop(NOP)) dut_wrap (
        .iClk(clk), .iRst(rst),
        .oMemReqValid(w_valid), .oMemReqAddr(w_addr), .iMemReqReady(1'b1),
        .iMemRspValid(w_rsp_valid), .iMemRspData(w_rsp_data),
        .iStall(1'b0), .iFlushPipe(1'b0), .iRedirectPc(32'h0),
        .oInst(w_inst), .oCurPc(w_pc), .oInstDv(w_dv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    // One-cycle memory for the wrap-around instance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            w_rsp_valid <= 1'b0;
            w_rsp_data  <= '0;
        end else begin
            w_rsp_valid <= w_valid;
            w_rsp_data  <= mem_word(w_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (rst) begin
            pend.delete();
            exp_pc    = '0;
            exp_req   = '0;
            prev_live = 1'b0;
            rsp_valid = 1'b0;
            rsp_data  = '0;
            #3;
            return;
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(pend[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
        #3;
        check("req_addr", req_addr, exp_req);
        if (flush) check("flush_noreq", 32'(req_valid), 32'd0);
        if (pend.size() >= 4) check("credit", 32'(req_valid), 32'd0);
        if (prev_live && prev_valid && !prev_ready && !flush) check("req_hold", 32'(req_valid), 32'd1);
        if (inst_dv) begin
            check("cur_pc", cur_pc, exp_pc);
            check("inst", inst, mem_word(exp_pc));
        end else begin
            check("nop", inst, NOP);
        end
    endtask

    task automatic advance();
        if (!rst) begin
            if (rsp_valid) void'(pend.pop_front());
            if (req_valid && ready) begin
                pend.push_back('{req_addr, cyc + lat});
                exp_req = exp_req + 32'd4;
            end
            if (flush) begin
                exp_req = redirect & ~32'd3;
                exp_pc  = redirect & ~32'd3;
            end else if (inst_dv && !stall) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            prev_valid = req_valid;
            prev_ready = ready;
            prev_live  = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; stall = 1'b0; flush = 1'b0; redirect = '0;
        rsp_valid = 1'b0; rsp_data = '0; lat = 1; cyc = 0; consumed = 0;
        exp_pc = '0; exp_req = '0; prev_valid = 1'b0; prev_ready = 1'b0; prev_live = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #4;
        check("rst_valid", 32'(req_valid), 32'd0);
        check("rst_addr", req_addr, 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_pc", cur_pc, 32'h0);
        check("rst_dv", 32'(inst_dv), 32'd0);
        check("rst_wrap_addr", w_addr, WRAP_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 1;

        // First request, latency and back-to-back throughput; wrap instance alongside
        for (int unsigned k = 1; k <= 20; k++) begin
            sample();
            if (k == 1) check("first_req", 32'(req_valid), 32'd1);
            check("dv_latency", 32'(inst_dv), 32'(k >= 3));
            if (k >= 3 && k <= 5) begin
                check("wrap_dv", 32'(w_dv), 32'd1);
                check("wrap_pc", w_pc, WRAP_PC + 32'(4 * (k - 3)));
                check("wrap_inst", w_inst, mem_word(WRAP_PC + 32'(4 * (k - 3))));
            end
            advance();
        end

        // Six-cycle decoder stall
        for (int unsigned k = 0; k < 6; k++) begin
            stall = 1'b1;
            sample();
            if (k == 5) check("stall_credit", 32'(req_valid), 32'd0);
            advance();
        end
        stall = 1'b0;
        repeat (15) step();

        // Three-cycle memory, flush to 0x100
        lat = 3;
        repeat (10) step();
        flush = 1'b1;
        redirect = 32'h100;
        step();
        flush = 1'b0;
        mark = consumed;
        sample();
        check("flush_dv", 32'(inst_dv), 32'd0);
        check("redirect_req", 32'(req_valid), 32'd1);
        check("redirect_addr", req_addr, 32'h100);
        advance();
        repeat (12) step();
        check("redirect_progress", 32'(consumed - mark >= 2), 32'd1);

        // Unaligned redirect with a response arriving in the flush cycle
        lat = 1;
        repeat (8) step();
        flush = 1'b1;
        redirect = 32'h203;
        step();
        flush = 1'b0;
        mark = consumed;
        sample();
        check("flush2_dv", 32'(inst_dv), 32'd0);
        check("redirect2_req", 32'(req_valid), 32'd1);
        check("redirect2_addr", req_addr, 32'h200);
        advance();
        repeat (6) step();
        check("redirect2_progress", 32'(consumed - mark >= 1), 32'd1);

        // Random ready / stall / flush / latency
        for (int unsigned i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            ready    = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 29) == 0);
            redirect = $urandom;
            step();
        end
        flush = 1'b0;
        stall = 1'b0;

        // Asynchronous reset in the middle of a burst
        for (int unsigned i = 0; i < 10; i++) begin
            ready = $urandom_range(0, 1) != 0;
            step();
        end
        rst = 1'b1;
        rsp_valid = 1'b0;
        #1;
        check("arst_valid", 32'(req_valid), 32'd0);
        check("arst_addr", req_addr, 32'h0);
        check("arst_inst", inst, NOP);
        check("arst_pc", cur_pc, 32'h0);
        check("arst_dv", 32'(inst_dv), 32'd0);
        step();
        step();
        ready = 1'b1;
        lat = 1;
        rst = 1'b0;
        sample();
        check("restart_req", 32'(req_valid), 32'd1);
        check("restart_addr", req_addr, 32'h0);
        advance();
        step();
        sample();
        check("restart_dv", 32'(inst_dv), 32'd1);
        advance();

        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
